// File: rtl/uart_frame_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command
// frame controller. Optional checksum byte enabled by UART_FRAME_CHKSUM_EN.
package uart_frame_pkg;

  localparam logic [7:0] HDR1        = 8'h55;
  localparam logic [7:0] HDR2        = 8'hA5;
  localparam logic [7:0] TAIL        = 8'hF0;
  localparam int         PAYLOAD_LEN = 5;
  localparam int         TIMER_W     = 24;

`ifdef UART_FRAME_CHKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR2    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_TAIL    = 3'd4
  } frame_state_t;

  // XOR of all payload bytes; this is the expected K byte
  function automatic logic [7:0] xor_bytes(input logic [PAYLOAD_LEN-1:0][7:0] bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      acc = acc ^ bytes[i];
    end
    return acc;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR2    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_TAIL    = 3'd4
  } frame_state_t;
`endif

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer: reloads to zero on every received byte, counts while
// enabled and saturates at TIMEOUT_CYC-1, where the expired flag is raised.
module uart_idle_timer
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic clk,
  input  logic srst,
  input  logic reload,
  input  logic enable,
  output logic expired
);

  localparam logic [TIMER_W-1:0] CNT_MAX = TIMER_W'(TIMEOUT_CYC - 1);

  logic [TIMER_W-1:0] cnt_reg;

  // Saturating counter: reload beats enable, holding at the limit never wraps
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (reload) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg == CNT_MAX);

endmodule

// File: rtl/uart_frame_cmd_ctrl.sv
// UART command frame parser: 55 A5 T3 T2 T1 T0 C [K] F0. A good frame commits
// time_set/ctrl and pulses cfg_valid; a bad trailer, bad checksum or an
// inter-byte timeout pulses frame_err. Checksum K present when
// UART_FRAME_CHKSUM_EN is defined.
module uart_frame_cmd_ctrl
  import uart_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 500000,
  parameter logic [7:0]  CTRL_RST    = 8'h00,
  parameter logic [31:0] TIME_RST    = 32'd24999999
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  ctrl,
  output logic [31:0] time_set,
  output logic        cfg_valid,
  output logic        frame_err
);

  frame_state_t state_reg, state_next;
  logic [2:0]   idx_reg, idx_next;
  logic         shadow_we;
  logic         commit;
  logic         err_next;
  logic         timer_expired;

  logic [PAYLOAD_LEN-1:0][7:0] shadow;

  logic [7:0]   ctrl_reg;
  logic [31:0]  time_reg;
  logic         cfg_valid_reg;
  logic         frame_err_reg;

  uart_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (Clk),
    .srst    (Reset),
    .reload  (rx_done),
    .enable  (state_reg != S_IDLE),
    .expired (timer_expired)
  );

  // Shadow byte registers, one per payload position; only a commit exposes them
  generate
    for (genvar gi = 0; gi < PAYLOAD_LEN; gi++) begin : g_shadow
      logic [7:0] byte_reg;

      // Capture the payload byte whose index matches this slot
      always_ff @(posedge Clk) begin
        if (Reset) begin
          byte_reg <= 8'h00;
        end else if (shadow_we && (idx_reg == 3'(gi))) begin
          byte_reg <= rx_data;
        end
      end

      assign shadow[gi] = byte_reg;
    end
  endgenerate

  // Next-state logic: a byte beats a simultaneous timeout
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    shadow_we  = 1'b0;
    commit     = 1'b0;
    err_next   = 1'b0;
    if (rx_done) begin
      case (state_reg)
        S_IDLE: begin
          if (rx_data == HDR1) state_next = S_HDR2;
        end
        S_HDR2: begin
          if (rx_data == HDR2) begin
            state_next = S_PAYLOAD;
            idx_next   = 3'd0;
          end else if (rx_data != HDR1) begin
            state_next = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          shadow_we = 1'b1;
          if (idx_reg == 3'(PAYLOAD_LEN - 1)) begin
`ifdef UART_FRAME_CHKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_TAIL;
`endif
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end
`ifdef UART_FRAME_CHKSUM_EN
        S_CHK: begin
          if (rx_data == xor_bytes(shadow)) begin
            state_next = S_TAIL;
          end else begin
            err_next   = 1'b1;
            state_next = S_IDLE;
          end
        end
`endif
        S_TAIL: begin
          if (rx_data == TAIL) begin
            commit = 1'b1;
          end else begin
            err_next = 1'b1;
          end
          state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end else if (timer_expired && (state_reg != S_IDLE)) begin
      err_next   = 1'b1;
      state_next = S_IDLE;
    end
  end

  // State, committed configuration and one-cycle status pulses
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= S_IDLE;
      idx_reg       <= 3'd0;
      ctrl_reg      <= CTRL_RST;
      time_reg      <= TIME_RST;
      cfg_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      cfg_valid_reg <= commit;
      frame_err_reg <= err_next;
      if (commit) begin
        time_reg <= {shadow[0], shadow[1], shadow[2], shadow[3]};
        ctrl_reg <= shadow[4];
      end
    end
  end

  assign ctrl      = ctrl_reg;
  assign time_set  = time_reg;
  assign cfg_valid = cfg_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: doc/uart_frame_cmd_ctrl.md
UART_FRAME_CMD_CTRL -- requirements
Module: uart_frame_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 500000, inter-byte timeout in Clk cycles (10 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter CTRL_RST, default 8'h00, reset value of ctrl.
REQ-003 Parameter TIME_RST, default 32'd24999999, reset value of time_set.
REQ-004 Clk  input  1  single clock for all logic; rising edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte; valid only while rx_done=1.
REQ-007 rx_done  input  1  one-cycle strobe, one per received byte.
REQ-008 ctrl  output  8  committed LED control word.
REQ-009 time_set  output  32  committed LED period value.
REQ-010 cfg_valid  output  1  one-cycle pulse on each commit.
REQ-011 frame_err  output  1  one-cycle pulse on each rejected frame.

Function
REQ-012 Frame format: 0x55, 0xA5, T3, T2, T1, T0 (time_set, MSB first), C (ctrl), [K when checksum enabled], 0xF0.
REQ-013 FSM states: IDLE, HDR2, PAYLOAD, CHK, TAIL; a byte is consumed only on a cycle with rx_done=1.
REQ-014 IDLE: 0x55 -> HDR2; any other byte is ignored, with no error.
REQ-015 HDR2: 0xA5 -> PAYLOAD with byte index 0; 0x55 -> stay in HDR2 (resync); any other byte -> IDLE, no error.
REQ-016 PAYLOAD: store bytes into shadow registers at index 0..4; after index 4 go to CHK when checksum is enabled, otherwise TAIL.
REQ-017 TAIL: 0xF0 -> commit shadow registers to time_set/ctrl, pulse cfg_valid, go to IDLE; any other byte -> pulse frame_err, go to IDLE, outputs unchanged.
REQ-018 Commit latency: time_set, ctrl and cfg_valid update on the first rising edge after the trailer's rx_done cycle.
REQ-019 ctrl and time_set change only on commit or reset; a partial frame never alters them.
REQ-020 Idle timer: reloads to 0 on every rx_done; counts while state != IDLE.
REQ-021 Timeout: timer reaching TIMEOUT_CYC-1 in a non-IDLE state pulses frame_err and forces IDLE; the timer saturates and does not wrap.
REQ-022 When rx_done and timeout fire in the same cycle, rx_done wins: the byte is processed and no timeout error is raised.
REQ-023 cfg_valid and frame_err are never asserted in the same cycle and are never longer than 1 cycle.
REQ-024 Back-to-back frames with no idle gap are accepted; the 0x55 immediately following a trailer starts a new frame.

Reset
REQ-025 Reset=1 at a rising edge: state=IDLE, timer=0, shadow registers=0, ctrl=CTRL_RST, time_set=TIME_RST, cfg_valid=0, frame_err=0.
REQ-026 Reset asserted mid-frame discards the partial frame with no frame_err pulse; Reset takes priority over rx_done.

Configuration
REQ-027 Macro UART_FRAME_CHKSUM_EN defined: the frame carries K = XOR of T3..C; in CHK, a match -> TAIL, a mismatch -> frame_err pulse and IDLE.
REQ-028 Macro UART_FRAME_CHKSUM_EN undefined: the CHK state and XOR logic are absent, and the frame is 8 bytes long.

Structure
REQ-029 Shared package uart_frame_pkg holds HDR1=8'h55, HDR2=8'hA5, TAIL=8'hF0, PAYLOAD_LEN=5 and the state encoding.
REQ-030 One sub-module, uart_idle_timer (reload, enable, saturating counter, expire flag), implements REQ-020/021; all other logic is inline.
REQ-031 The block sits between uart_byte_rx (rx_data/rx_done) and led_flash_s4 (Ctrl/Time).

Verification
REQ-032 Frame 55 A5 01 31 2D 00 03 [K=0x1E] F0 -> one cfg_valid pulse; time_set=32'h01312D00, ctrl=8'h03 on the next edge.
REQ-033 Same frame with trailer 0xF1 -> one frame_err pulse; ctrl/time_set keep their previous values; cfg_valid stays 0.
REQ-034 Bytes 55 A5 01 31, then silence for TIMEOUT_CYC cycles -> one frame_err pulse and return to IDLE; a following good frame commits normally.
REQ-035 Stream 55 55 55 A5 + valid payload/trailer -> commit (resync); stray byte 0x12 while in IDLE -> no response.
REQ-036 Reset pulse after 3 payload bytes -> outputs return to CTRL_RST/TIME_RST with no frame_err; the next full frame commits.
REQ-037 With UART_FRAME_CHKSUM_EN defined, a bad K byte -> frame_err; rx_done injected in the exact timeout cycle -> byte accepted, no frame_err.
